// File: rtl/iter_multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, state encoding, constants.
package iter_multdiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ITER   = 32;

    localparam logic [DATA_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMult = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/iter_multdiv_if.sv
// Start/operand/result bundle between pipeline control (master) and the multdiv unit (slave).
interface iter_multdiv_if
    import iter_multdiv_pkg::*;
();

    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;
    logic              busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/cla_adder.sv
// 32-bit adder built from 4-bit carry-lookahead groups with rippled group carries.
module cla_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    // Lookahead carries inside each nibble; the nibble carry-out feeds the next group.
    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        c = '0;
        c[0] = cin_i;
        for (int grp = 0; grp < 8; grp++) begin
            c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+4] = g[4*grp+3] | (p[4*grp+3] & g[4*grp+2])
                       | (p[4*grp+3] & p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+3] & p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
        end
        sum_o  = p ^ c[31:0];
        cout_o = c[32];
    end

endmodule

// File: rtl/iter_multdiv_step.sv
// One combinational Booth-multiply or non-restoring-divide iteration over {acc, q, q-1}.
// Divide datapath present only when MULTDIV_DIV_EN is defined.
module iter_multdiv_step
    import iter_multdiv_pkg::*;
(
`ifdef MULTDIV_DIV_EN
    input  logic              is_div_i,
`endif
    input  logic [DATA_W-1:0] acc_i,
    input  logic [DATA_W-1:0] q_i,
    input  logic              qm1_i,
    input  logic [DATA_W-1:0] opnd_i,
    output logic [DATA_W-1:0] acc_o,
    output logic [DATA_W-1:0] q_o,
    output logic              qm1_o
);

    logic [DATA_W-1:0] add_a;
    logic [DATA_W-1:0] add_b;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] res;
    logic              sub;
    logic              pass;
    logic              cout;
    logic              sign;

    // Operation select: Booth pair {q[0], q-1} for multiply, remainder sign for divide.
    always_comb begin
        add_a = acc_i;
        sub   = q_i[0] & ~qm1_i;
        pass  = (q_i[0] == qm1_i);
`ifdef MULTDIV_DIV_EN
        if (is_div_i) begin
            add_a = {acc_i[DATA_W-2:0], q_i[DATA_W-1]};
            sub   = ~acc_i[DATA_W-1];
            pass  = 1'b0;
        end
`endif
        add_b = sub ? ~opnd_i : opnd_i;
    end

    cla_adder u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (sub),
        .sum_o (sum),
        .cout_o(cout)
    );

    // Next register value; the multiply shift-in is the true 33-bit sign so INT_MIN works.
    always_comb begin
        res   = pass ? acc_i : sum;
        sign  = pass ? acc_i[DATA_W-1] : (add_a[DATA_W-1] ^ add_b[DATA_W-1] ^ cout);
        acc_o = {sign, res[DATA_W-1:1]};
        q_o   = {res[0], q_i[DATA_W-1:1]};
        qm1_o = q_i[0];
`ifdef MULTDIV_DIV_EN
        if (is_div_i) begin
            acc_o = sum;
            q_o   = {q_i[DATA_W-2:0], ~sum[DATA_W-1]};
            qm1_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/iter_multdiv.sv
// Multicycle signed 32-bit multiply/divide: FSM, counter, operand latches, sign fixup, exceptions.
// Define MULTDIV_DIV_EN to include the divide path; otherwise ctrl_DIV is ignored.
module iter_multdiv
    import iter_multdiv_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input logic          clock,
    input logic          reset_n,
    iter_multdiv_if.slave bus
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ITER - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] opnd_q, acc_q, q_q;
    logic              qm1_q;
    logic [DATA_W-1:0] result_q;
    logic              exc_q, rdy_q, busy_q;

    logic [DATA_W-1:0] acc_n, q_n;
    logic              qm1_n;
    logic [DATA_W-1:0] fin_res;
    logic              fin_exc;
    logic              start_mult, running;

    assign start_mult = bus.ctrl_MULT;

`ifdef MULTDIV_DIV_EN
    logic              neg_q, dz_q, ovf_q;
    logic              start_div, is_div;
    logic [DATA_W-1:0] abs_a, abs_b;

    assign start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign is_div    = (state_q == StDiv);
    assign running   = (state_q == StMult) || is_div;
    assign abs_a     = bus.data_operandA[DATA_W-1] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b     = bus.data_operandB[DATA_W-1] ? -bus.data_operandB : bus.data_operandB;
`else
    logic unused_div;

    assign unused_div = bus.ctrl_DIV;
    assign running    = (state_q == StMult);
`endif

    iter_multdiv_step u_step (
`ifdef MULTDIV_DIV_EN
        .is_div_i(is_div),
`endif
        .acc_i   (acc_q),
        .q_i     (q_q),
        .qm1_i   (qm1_q),
        .opnd_i  (opnd_q),
        .acc_o   (acc_n),
        .q_o     (q_n),
        .qm1_o   (qm1_n)
    );

    // Final result/exception from the last iteration's output, with divide sign fixup.
    always_comb begin
        fin_res = q_n;
        fin_exc = (acc_n != {DATA_W{q_n[DATA_W-1]}});
`ifdef MULTDIV_DIV_EN
        if (is_div) begin
            fin_res = dz_q ? '0 : (neg_q ? -q_n : q_n);
            fin_exc = dz_q | ovf_q;
        end
`endif
    end

    // FSM with registered outputs; a start pulse in any state restarts from iteration 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (start_mult) begin
                state_q <= StMult;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                opnd_q  <= bus.data_operandA;
                acc_q   <= '0;
                q_q     <= bus.data_operandB;
                qm1_q   <= 1'b0;
            end
`ifdef MULTDIV_DIV_EN
            else if (start_div) begin
                state_q <= StDiv;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                opnd_q  <= abs_b;
                acc_q   <= '0;
                q_q     <= abs_a;
                qm1_q   <= 1'b0;
                neg_q   <= bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
                dz_q    <= (bus.data_operandB == '0);
                ovf_q   <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
            end
`endif
            else if (running) begin
                acc_q <= acc_n;
                q_q   <= q_n;
                qm1_q <= qm1_n;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    state_q  <= StDone;
                    busy_q   <= 1'b0;
                    rdy_q    <= 1'b1;
                    result_q <= fin_res;
                    exc_q    <= fin_exc;
                end
            end else if (state_q == StDone) begin
                state_q <= StIdle;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_iter_multdiv.sv
// Self-checking bench for iter_multdiv: directed and random operations against a plain
// arithmetic reference. Divide scenarios are exercised when MULTDIV_DIV_EN is defined.
module tb_iter_multdiv;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    iter_multdiv_if bus ();

    iter_multdiv #(.CNT_W(6)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Reference: {exception, result} from the true 64-bit signed product.
    function automatic logic [32:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return {p[63:32] != {32{p[31]}}, p[31:0]};
    endfunction

    // Reference: {exception, result} for signed division truncating toward zero.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int q;
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, 32'(q)};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 4)];
            1:       return 32'($signed($urandom_range(0, 2000)) - 1000);
            default: return $urandom;
        endcase
    endfunction

    // Start at cycle 0, then check busy/RDY timing for cycles 1..34 and the result at 33.
    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input logic [32:0] exp, input string name);
        bit bad_timing = 0;
        @(negedge clock);
        bus.ctrl_MULT = m;
        bus.ctrl_DIV = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        for (int k = 1; k <= 34; k++) begin
            if (bus.busy !== (k <= 32) || bus.data_resultRDY !== (k == 33)) bad_timing = 1;
            if (k == 33) begin
                n_tests++;
                if (bus.data_result !== exp[31:0]) begin
                    n_fail++;
                    $display("FAIL %s result: got %h want %h (a=%h b=%h)", name,
                             bus.data_result, exp[31:0], a, b);
                end
                n_tests++;
                if (bus.data_exception !== exp[32]) begin
                    n_fail++;
                    $display("FAIL %s exception: got %b want %b (a=%h b=%h)", name,
                             bus.data_exception, exp[32], a, b);
                end
            end
            if (k == 34) begin
                n_tests++;
                if ({bus.data_exception, bus.data_result} !== exp) begin
                    n_fail++;
                    $display("FAIL %s hold: got %h want %h", name,
                             {bus.data_exception, bus.data_result}, exp);
                end
            end
            if (k < 34) @(negedge clock);
        end
        n_tests++;
        if (bad_timing) begin
            n_fail++;
            $display("FAIL %s timing: busy/RDY not high exactly in cycles 1-32 / 33", name);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        n_tests++;
        if ({bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b rdy=%b exc=%b res=%h want all 0",
                     bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mult_directed();
        run_op(1, 0, 32'd7, -32'sd3, {1'b0, 32'hFFFF_FFEB}, "mult_7x-3");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, {1'b1, 32'h0}, "mult_ovf");
        run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'h1}, "mult_-1x-1");
        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, ref_mult(32'h8000_0000, 32'h8000_0000),
               "mult_minxmin");
        run_op(1, 1, 32'd5, 32'd3, {1'b0, 32'd15}, "mult_wins");
    endtask

    task automatic test_mult_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a = pick_operand();
            logic [31:0] b = pick_operand();
            run_op(1, 0, a, b, ref_mult(a, b), $sformatf("mult_rand%0d", i));
        end
    endtask

`ifdef MULTDIV_DIV_EN
    task automatic test_div_directed();
        run_op(0, 1, -32'sd7, 32'd2, {1'b0, 32'hFFFF_FFFD}, "div_-7/2");
        run_op(0, 1, 32'd100, 32'd7, {1'b0, 32'd14}, "div_100/7");
        run_op(0, 1, 32'd5, 32'd0, {1'b1, 32'h0}, "div_by_zero");
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, {1'b1, 32'h8000_0000}, "div_min/-1");
        run_op(0, 1, 32'h8000_0000, 32'd1, ref_div(32'h8000_0000, 32'd1), "div_min/1");
    endtask

    task automatic test_div_random();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a = pick_operand();
            logic [31:0] b = pick_operand();
            run_op(0, 1, a, b, ref_div(a, b), $sformatf("div_rand%0d", i));
        end
    endtask
`else
    task automatic test_div_ignored();
        bit seen = 0;
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd3;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0) seen = 1;
            @(negedge clock);
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL div_ignored: got busy/RDY activity want none");
        end
    endtask
`endif

    // Restart at cycle 10 of a multiply: single RDY at cycle 43 with the second product.
    task automatic test_restart();
        bit bad_timing = 0;
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            if (bus.busy !== (k <= 42) || bus.data_resultRDY !== (k == 43)) bad_timing = 1;
            if (k == 43) begin
                n_tests++;
                if ({bus.data_exception, bus.data_result} !== {1'b0, 32'd12}) begin
                    n_fail++;
                    $display("FAIL restart_result: got %h want %h",
                             {bus.data_exception, bus.data_result}, {1'b0, 32'd12});
                end
            end
            if (k == 10) begin
                bus.ctrl_MULT = 1'b1;
                bus.data_operandA = 32'd3;
                bus.data_operandB = 32'd4;
            end else begin
                bus.ctrl_MULT = 1'b0;
                bus.data_operandA = $urandom;
                bus.data_operandB = $urandom;
            end
            @(negedge clock);
        end
        n_tests++;
        if (bad_timing) begin
            n_fail++;
            $display("FAIL restart_timing: RDY not only at cycle 43 or busy wrong");
        end
    endtask

    // Second start issued in the DONE cycle of the first; each gets its own RDY.
    task automatic test_back_to_back();
        bit          bad_timing = 0;
        logic [31:0] a1 = pick_operand();
        logic [31:0] b1 = pick_operand();
        logic [31:0] a2 = pick_operand();
        logic [31:0] b2 = pick_operand();
        logic [32:0] e2;
`ifdef MULTDIV_DIV_EN
        bit          second_div = 1;
        e2 = ref_div(a2, b2);
`else
        bit          second_div = 0;
        e2 = ref_mult(a2, b2);
`endif
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = a1;
        bus.data_operandB = b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        for (int k = 1; k <= 67; k++) begin
            if (bus.busy !== ((k <= 32) || (k >= 34 && k <= 65)) ||
                bus.data_resultRDY !== (k == 33 || k == 66)) bad_timing = 1;
            if (k == 33 || k == 66) begin
                logic [32:0] exp;
                exp = (k == 33) ? ref_mult(a1, b1) : e2;
                n_tests++;
                if ({bus.data_exception, bus.data_result} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got %h want %h", k,
                             {bus.data_exception, bus.data_result}, exp);
                end
            end
            if (k == 33) begin
                bus.ctrl_MULT = ~second_div;
                bus.ctrl_DIV = second_div;
                bus.data_operandA = a2;
                bus.data_operandB = b2;
            end else begin
                bus.ctrl_MULT = 1'b0;
                bus.ctrl_DIV = 1'b0;
            end
            @(negedge clock);
        end
        n_tests++;
        if (bad_timing) begin
            n_fail++;
            $display("FAIL b2b_timing: RDY/busy pattern wrong across chained operations");
        end
    endtask

    // Reset in cycle 15 of an operation clears outputs at once and suppresses its RDY.
    task automatic test_reset_mid();
        bit seen = 0;
        @(negedge clock);
`ifdef MULTDIV_DIV_EN
        bus.ctrl_DIV = 1'b1;
`else
        bus.ctrl_MULT = 1'b1;
`endif
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        repeat (14) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got busy=%b rdy=%b exc=%b res=%h want all 0",
                     bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0) seen = 1;
            @(negedge clock);
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_no_rdy: got busy/RDY after reset want none");
        end
`ifdef MULTDIV_DIV_EN
        run_op(0, 1, 32'd9, 32'd3, {1'b0, 32'd3}, "div_after_reset");
`else
        run_op(1, 0, 32'd9, 32'd3, {1'b0, 32'd27}, "mult_after_reset");
`endif
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_mult_random();
`ifdef MULTDIV_DIV_EN
        test_div_directed();
        test_div_random();
`else
        test_div_ignored();
`endif
        test_restart();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iter_multdiv.md
Name: iter_multdiv

Overview:
- Multicycle signed 32-bit multiply/divide unit in the execute stage, beside the ALU.
- Built around one 32-bit carry-lookahead adder datapath:
  - radix-2 Booth multiply (add/subtract multiplicand per step);
  - non-restoring divide (add/subtract divisor per step).
- Raises data_resultRDY when done; pipeline control stalls on it.

Parameters:
- DATA_W, 32, operand/result width; only 32 supported (matches adder width).
- ITER, 32, iterations per operation.
- CNT_W, 6, iteration counter width; must hold ITER.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- ctrl_MULT  input  1  one-cycle start pulse, signed multiply.
- ctrl_DIV  input  1  one-cycle start pulse, signed divide.
- data_operandA  input  32  multiplicand / dividend; sampled only on start cycle.
- data_operandB  input  32  multiplier / divisor; sampled only on start cycle.
- data_result  output  32  product low word or quotient.
- data_exception  output  1  overflow or divide-by-zero flag for the result.
- data_resultRDY  output  1  one-cycle pulse: result/exception valid.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Clock and reset: one clock (clock). reset_n is asynchronous, active-low.
- On reset: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- FSM states: IDLE, MULT, DIV, DONE.
  - IDLE -> MULT on ctrl_MULT; IDLE -> DIV on ctrl_DIV.
  - MULT/DIV -> DONE after ITER iterations.
  - DONE -> IDLE next cycle.
- Start cycle = cycle 0 (start pulse sampled at the edge ending it). Operands latch at that edge.
- Iterations run in cycles 1..32, one adder pass each.
- In cycle 33: data_resultRDY=1 for exactly one cycle; data_result and data_exception are valid.
- Fixed latency for every operand value, including divide-by-zero.
- data_result and data_exception hold their values after RDY until the next start. busy=1 from cycle 1 through cycle 32.
- Start pulse in any state, including mid-operation or the DONE cycle:
  - aborts the current operation with no RDY for it;
  - relatches operands and restarts at iteration 0.
- ctrl_MULT and ctrl_DIV in the same cycle: MULT wins, DIV ignored.
- Multiply:
  - Booth over a 65-bit {acc, Q, q-1} register; arithmetic right shift each step.
  - Result = product[31:0].
  - data_exception=1 iff product[63:32] is not the sign extension of product[31].
- Divide:
  - Operates on magnitudes. Quotient sign = A[31]^B[31]; truncates toward zero; remainder discarded.
  - B==0: result=0, exception=1.
  - A=0x80000000 and B=0xFFFFFFFF: result=0x80000000, exception=1.
- All adds/subtracts: 32-bit, carry-in=1 for subtract (two's complement of B). Adder overflow output unused.
- reset_n asserted mid-operation: immediate return to reset values; no RDY pulse.

Optional Feature:
- Macro MULTDIV_DIV_EN.
- Defined: divide path, DIV state and divide exceptions are present.
- Undefined:
  - ctrl_DIV is ignored (no start, no abort, no RDY).
  - The DIV state and divisor/remainder logic are removed.
  - Multiply behaviour and latency are unchanged.

Decomposition:
- Shared package (processor defines file):
  - state encodings: IDLE=2'd0, MULT=2'd1, DIV=2'd2, DONE=2'd3;
  - DATA_W and ITER constants;
  - INT_MIN constant 0x80000000.
- One sub-module, multdiv_step: combinational iteration.
  - Selects add/subtract/pass from Booth bits or the remainder sign.
  - Instantiates the team's 32-bit cla_adder.
  - Produces the next shifted register value.
- The top holds the FSM, counter, operand latches, sign fixup and exception logic.

Test Plan:
- ctrl_MULT, A=7, B=-3 -> RDY pulse in cycle 33 only; result=0xFFFFFFEB; exception=0; busy high cycles 1-32.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1; A=-1, B=-1 -> result=1, exception=0.
- ctrl_DIV, A=-7, B=2 -> result=0xFFFFFFFD (-3); A=100, B=7 -> 14; both exception=0.
- ctrl_DIV, A=5, B=0 -> cycle 33: result=0, exception=1. A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Restart: ctrl_MULT 6*7, then ctrl_MULT 3*4 at cycle 10 -> single RDY at cycle 43 (33 cycles after the restart), result=12; no RDY at cycle 33.
- Reset: reset_n low at cycle 15 of a divide -> outputs 0 immediately, no RDY; ctrl_DIV A=9, B=3 after release -> result=3.
